// File: rtl/ysyx_220066_lsu.sv
// rtl/ysyx_220066_lsu.sv - multi-cycle load/store unit with one outstanding bus transaction
module ysyx_220066_lsu #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic [63:0] ex_addr,
  input  logic [2:0]  ex_memop,
  input  logic        ex_wr,
  input  logic [63:0] ex_wdata,
  output logic        wb_valid,
  input  logic        wb_ready,
  output logic [63:0] wb_rdata,
  output logic        wb_err,
  output logic        bus_req,
  input  logic        bus_gnt,
  output logic        bus_we,
  output logic [63:0] bus_addr,
  output logic [63:0] bus_wdata,
  output logic [7:0]  bus_wmask,
  input  logic        bus_rvalid,
  input  logic [63:0] bus_rdata,
  input  logic        bus_rerr
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t      state, state_nx;
  logic [63:0] addr_q, wdata_q, rdata_q;
  logic [2:0]  memop_q;
  logic        wr_q, err_q;
  logic [CNT_W-1:0] cnt;

  logic        bad;
  logic        timeout_hit;
  logic [63:0] shifted;
  logic [63:0] load_val;
  logic [63:0] st_data;
  logic [7:0]  st_mask;

  // Reject illegal encodings and accesses not aligned to their natural size
  always_comb begin
    bad = 1'b0;
    if (ex_memop == 3'b111) bad = 1'b1;
    if (ex_wr && ex_memop[2]) bad = 1'b1;
    case (ex_memop[1:0])
      2'b01:   if (ex_addr[0])        bad = 1'b1;
      2'b10:   if (ex_addr[1:0] != 0) bad = 1'b1;
      2'b11:   if (ex_addr[2:0] != 0) bad = 1'b1;
      default: ;
    endcase
  end

  assign timeout_hit = (cnt == CNT_W'(TIMEOUT - 1));

  // Load path: shift the addressed lane down to bit 0, then extend by size
  always_comb begin
    shifted  = bus_rdata >> {addr_q[2:0], 3'b000};
    load_val = shifted;
    case (memop_q[1:0])
      2'b00:   load_val = memop_q[2] ? {56'b0, shifted[7:0]}  : {{56{shifted[7]}}, shifted[7:0]};
      2'b01:   load_val = memop_q[2] ? {48'b0, shifted[15:0]} : {{48{shifted[15]}}, shifted[15:0]};
      2'b10:   load_val = memop_q[2] ? {32'b0, shifted[31:0]} : {{32{shifted[31]}}, shifted[31:0]};
      default: load_val = shifted;
    endcase
  end

  // Store path: replicate the datum across all lanes and enable only the addressed bytes
  always_comb begin
    st_data = wdata_q;
    st_mask = 8'hFF;
    case (memop_q[1:0])
      2'b00: begin
        st_data = {8{wdata_q[7:0]}};
        st_mask = 8'b0000_0001 << addr_q[2:0];
      end
      2'b01: begin
        st_data = {4{wdata_q[15:0]}};
        st_mask = 8'b0000_0011 << {addr_q[2:1], 1'b0};
      end
      2'b10: begin
        st_data = {2{wdata_q[31:0]}};
        st_mask = addr_q[2] ? 8'hF0 : 8'h0F;
      end
      default: begin
        st_data = wdata_q;
        st_mask = 8'hFF;
      end
    endcase
  end

  // Next-state: timeout overrides any handshake in ISSUE/WAIT
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if (ex_valid) state_nx = bad ? DONE : ISSUE;
      ISSUE: if (timeout_hit) state_nx = DONE;
             else if (bus_gnt) state_nx = WAIT;
      WAIT:  if (timeout_hit) state_nx = DONE;
             else if (bus_rvalid) state_nx = DONE;
      DONE:  if (wb_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  // Operation latch, timeout counter and result capture
  always_ff @(posedge clk) begin
    if (!rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
      memop_q <= '0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      cnt     <= '0;
    end else begin
      case (state)
        IDLE: if (ex_valid) begin
          addr_q  <= ex_addr;
          wdata_q <= ex_wdata;
          memop_q <= ex_memop;
          wr_q    <= ex_wr;
          err_q   <= bad;
          rdata_q <= '0;
          cnt     <= '0;
        end
        ISSUE, WAIT: begin
          cnt <= cnt + CNT_W'(1);
          if (timeout_hit) begin
            err_q   <= 1'b1;
            rdata_q <= '0;
          end else if (state == WAIT && bus_rvalid) begin
            err_q   <= bus_rerr;
            rdata_q <= (bus_rerr || wr_q) ? 64'b0 : load_val;
          end
        end
        default: ;
      endcase
    end
  end

  assign ex_ready  = (state == IDLE);
  assign wb_valid  = (state == DONE);
  assign wb_rdata  = (state == DONE) ? rdata_q : 64'b0;
  assign wb_err    = (state == DONE) ? err_q : 1'b0;
  assign bus_req   = (state == ISSUE);
  assign bus_we    = (state == ISSUE) && wr_q;
  assign bus_addr  = (state == ISSUE) ? {addr_q[63:3], 3'b000} : 64'b0;
  assign bus_wdata = (state == ISSUE && wr_q) ? st_data : 64'b0;
  assign bus_wmask = (state == ISSUE && wr_q) ? st_mask : 8'b0;

endmodule

// File: tb/tb_ysyx_220066_lsu.sv
// tb/tb_ysyx_220066_lsu.sv - randomized self-checking bench for the load/store unit
module tb_ysyx_220066_lsu;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ex_valid = 1'b0;
  logic        ex_ready;
  logic [63:0] ex_addr = '0;
  logic [2:0]  ex_memop = '0;
  logic        ex_wr = 1'b0;
  logic [63:0] ex_wdata = '0;
  logic        wb_valid;
  logic        wb_ready = 1'b0;
  logic [63:0] wb_rdata;
  logic        wb_err;
  logic        bus_req;
  logic        bus_gnt = 1'b0;
  logic        bus_we;
  logic [63:0] bus_addr;
  logic [63:0] bus_wdata;
  logic [7:0]  bus_wmask;
  logic        bus_rvalid = 1'b0;
  logic [63:0] bus_rdata = '0;
  logic        bus_rerr = 1'b0;

  int n_pass = 0;
  int n_total = 0;
  logic [63:0] last_rdata, last_wdata;
  logic [7:0]  last_wmask;
  logic        last_err;

  ysyx_220066_lsu #(.TIMEOUT(255), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_addr(ex_addr), .ex_memop(ex_memop),
    .ex_wr(ex_wr), .ex_wdata(ex_wdata),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rdata(wb_rdata), .wb_err(wb_err),
    .bus_req(bus_req), .bus_gnt(bus_gnt), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_wmask(bus_wmask),
    .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata), .bus_rerr(bus_rerr)
  );

  always #5 clk = ~clk;

  task automatic chk64(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", name, act, exp);
  endtask

  // Reference model: access size, legality and byte-lane view of the bus word
  function automatic int nbytes(input logic [2:0] m);
    return 1 << m[1:0];
  endfunction

  function automatic logic model_bad(input logic [63:0] a, input logic [2:0] m, input logic wr);
    return (m == 3'b111) || (wr && m[2]) || ((int'(a[2:0]) % nbytes(m)) != 0);
  endfunction

  function automatic logic [7:0] model_mask(input logic [63:0] a, input logic [2:0] m);
    logic [7:0] r;
    int o, n;
    o = int'(a[2:0]);
    n = nbytes(m);
    for (int i = 0; i < 8; i++) r[i] = (i >= o) && (i < o + n);
    return r;
  endfunction

  function automatic logic [63:0] model_wdata(input logic [2:0] m, input logic [63:0] wd);
    logic [63:0] r;
    int n;
    n = nbytes(m);
    for (int i = 0; i < 8; i++) r[8*i +: 8] = wd[8*(i % n) +: 8];
    return r;
  endfunction

  function automatic logic [63:0] model_load(input logic [63:0] rd, input logic [63:0] a, input logic [2:0] m);
    logic [63:0] v;
    int o, n;
    o = int'(a[2:0]);
    n = nbytes(m);
    v = '0;
    for (int i = 0; i < n; i++) v[8*i +: 8] = rd[8*(o+i) +: 8];
    if (!m[2] && n < 8 && v[8*n-1])
      for (int i = n; i < 8; i++) v[8*i +: 8] = 8'hFF;
    return v;
  endfunction

  task automatic chk_reset_outputs(input string tag);
    chk1({tag, "_ex_ready"}, ex_ready, 1'b1);
    chk1({tag, "_wb_valid"}, wb_valid, 1'b0);
    chk1({tag, "_wb_err"}, wb_err, 1'b0);
    chk64({tag, "_wb_rdata"}, wb_rdata, 64'd0);
    chk1({tag, "_bus_req"}, bus_req, 1'b0);
    chk1({tag, "_bus_we"}, bus_we, 1'b0);
    chk64({tag, "_bus_addr"}, bus_addr, 64'd0);
    chk64({tag, "_bus_wdata"}, bus_wdata, 64'd0);
    chk64({tag, "_bus_wmask"}, 64'(bus_wmask), 64'd0);
  endtask

  // One full operation: drive the request, act as bus slave, check every cycle against the model
  task automatic run_op(input logic [63:0] a, input logic [2:0] m, input logic wr, input logic [63:0] wd,
                        input int gd, input int rdl, input logic [63:0] rdat, input logic rerr,
                        input int rdy, input logic viol);
    logic isbad, ee;
    logic [63:0] er;
    isbad = model_bad(a, m, wr);
    @(negedge clk);
    chk1("ex_ready_idle", ex_ready, 1'b1);
    ex_valid = 1'b1; ex_addr = a; ex_memop = m; ex_wr = wr; ex_wdata = wd;
    @(posedge clk); #1;
    ex_valid = 1'b0;
    if (isbad) begin
      ee = 1'b1;
      er = '0;
    end else begin
      for (int c = 0; c <= gd; c++) begin
        @(negedge clk);
        chk1("bus_req_issue", bus_req, 1'b1);
        chk64("bus_addr", bus_addr, {a[63:3], 3'b000});
        chk1("bus_we", bus_we, wr);
        chk64("bus_wmask", 64'(bus_wmask), wr ? 64'(model_mask(a, m)) : 64'd0);
        if (wr) chk64("bus_wdata", bus_wdata, model_wdata(m, wd));
        chk1("wb_valid_issue", wb_valid, 1'b0);
        last_wmask = bus_wmask;
        last_wdata = bus_wdata;
        if (c == gd) begin
          bus_gnt = 1'b1;
          if (viol) begin
            bus_rvalid = 1'b1; bus_rdata = {$urandom, $urandom}; bus_rerr = 1'b1;
          end
        end
      end
      @(posedge clk); #1;
      bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rerr = 1'b0;
      for (int c = 0; c <= rdl; c++) begin
        @(negedge clk);
        chk1("bus_req_wait", bus_req, 1'b0);
        chk1("wb_valid_wait", wb_valid, 1'b0);
        if (c == rdl) begin
          bus_rvalid = 1'b1; bus_rdata = rdat; bus_rerr = rerr;
        end
      end
      @(posedge clk); #1;
      bus_rvalid = 1'b0; bus_rerr = 1'b0;
      ee = rerr;
      er = (wr || rerr) ? 64'd0 : model_load(rdat, a, m);
    end
    for (int c = 0; c <= rdy; c++) begin
      @(negedge clk);
      chk1("wb_valid_done", wb_valid, 1'b1);
      chk1("wb_err", wb_err, ee);
      chk64("wb_rdata", wb_rdata, er);
      chk1("ex_ready_busy", ex_ready, 1'b0);
      chk1("bus_req_done", bus_req, 1'b0);
      if (c == 0) begin
        last_rdata = wb_rdata;
        last_err = wb_err;
      end
      if (c == rdy) wb_ready = 1'b1;
    end
    @(posedge clk); #1;
    wb_ready = 1'b0;
  endtask

  initial begin
    logic [63:0] a, wd, rd;
    logic [2:0]  m;
    logic        wr;
    int          reqcnt;
    logic        done;

    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk_reset_outputs("reset");

    chk64("model_pin_lh", model_load(64'h1122_3344_8566_7788, 64'h2, 3'b001), 64'hFFFF_FFFF_FFFF_8566);
    chk64("model_pin_mask_sh", 64'(model_mask(64'h8000_0006, 3'b001)), 64'hC0);

    run_op(64'h8000_0003, 3'b000, 1'b0, 64'd0, 0, 0, 64'h1122_3344_8566_7788, 1'b0, 0, 1'b0);
    chk64("lit_lb", last_rdata, 64'hFFFF_FFFF_FFFF_FF85);
    chk1("lit_lb_err", last_err, 1'b0);
    run_op(64'h8000_0003, 3'b100, 1'b0, 64'd0, 0, 0, 64'h1122_3344_8566_7788, 1'b0, 0, 1'b0);
    chk64("lit_lbu", last_rdata, 64'h85);
    run_op(64'h8000_0005, 3'b000, 1'b0, 64'd0, 0, 0, 64'h1122_3344_8566_7788, 1'b0, 0, 1'b0);
    chk64("lit_lb_off5", last_rdata, 64'h33);

    run_op(64'h8000_0006, 3'b001, 1'b1, 64'hABCD, 0, 0, 64'hDEAD_BEEF_0000_0000, 1'b0, 0, 1'b0);
    chk64("lit_sh_mask", 64'(last_wmask), 64'hC0);
    chk64("lit_sh_wdata", last_wdata, 64'hABCD_ABCD_ABCD_ABCD);
    chk64("lit_sh_rdata", last_rdata, 64'd0);

    run_op(64'h8000_0002, 3'b010, 1'b0, 64'd0, 0, 0, 64'd0, 1'b0, 0, 1'b0);
    chk1("lit_lw_mis_err", last_err, 1'b1);
    run_op(64'h8000_0004, 3'b011, 1'b0, 64'd0, 0, 0, 64'd0, 1'b0, 0, 1'b0);
    chk1("lit_ld_mis_err", last_err, 1'b1);
    run_op(64'h8000_0000, 3'b111, 1'b0, 64'd0, 0, 0, 64'd0, 1'b0, 0, 1'b0);
    chk1("lit_illegal_err", last_err, 1'b1);

    run_op(64'h8000_0010, 3'b011, 1'b0, 64'd0, 2, 3, 64'h0123_4567_89AB_CDEF, 1'b0, 5, 1'b0);
    run_op(64'h8000_0018, 3'b010, 1'b1, 64'h1234_5678, 0, 0, 64'd0, 1'b0, 0, 1'b1);

    for (int k = 0; k < 60; k++) begin
      m = 3'($urandom_range(0, 7));
      if (m == 3'b111 && ($urandom % 3) != 0) m = 3'b011;
      wr = 1'($urandom % 2);
      if (wr && ($urandom % 8) != 0) m[2] = 1'b0;
      a = {$urandom, $urandom};
      if (($urandom % 6) != 0) a[2:0] = a[2:0] & ~3'(nbytes(m) - 1);
      wd = {$urandom, $urandom};
      rd = {$urandom, $urandom};
      run_op(a, m, wr, wd, $urandom_range(0, 6), $urandom_range(0, 6), rd,
             1'(($urandom % 7) == 0), $urandom_range(0, 3), 1'(($urandom % 5) == 0));
    end

    @(negedge clk);
    ex_valid = 1'b1; ex_addr = 64'h8000_0008; ex_memop = 3'b011; ex_wr = 1'b0;
    @(posedge clk); #1;
    ex_valid = 1'b0;
    reqcnt = 0;
    done = 1'b0;
    for (int c = 0; c < 300 && !done; c++) begin
      @(negedge clk);
      if (wb_valid) done = 1'b1;
      else if (bus_req) reqcnt++;
    end
    chk1("timeout_reached", done, 1'b1);
    chk64("timeout_req_cycles", 64'(reqcnt), 64'd255);
    chk1("timeout_err", wb_err, 1'b1);
    chk64("timeout_rdata", wb_rdata, 64'd0);
    chk1("timeout_bus_req", bus_req, 1'b0);
    wb_ready = 1'b1;
    @(posedge clk); #1;
    wb_ready = 1'b0;
    @(negedge clk);
    bus_rvalid = 1'b1; bus_rdata = 64'h55;
    @(posedge clk); #1;
    bus_rvalid = 1'b0;
    @(negedge clk);
    chk1("late_rvalid_no_wb", wb_valid, 1'b0);
    chk1("late_rvalid_ready", ex_ready, 1'b1);

    ex_valid = 1'b1; ex_addr = 64'h8000_0020; ex_memop = 3'b011; ex_wr = 1'b0;
    @(posedge clk); #1;
    ex_valid = 1'b0;
    @(negedge clk);
    chk1("rst_test_issue", bus_req, 1'b1);
    bus_gnt = 1'b1;
    @(posedge clk); #1;
    bus_gnt = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk_reset_outputs("midrst");
    bus_rvalid = 1'b1; bus_rdata = 64'hFFFF;
    @(posedge clk); #1;
    bus_rvalid = 1'b0;
    @(negedge clk);
    chk1("midrst_rvalid_no_wb", wb_valid, 1'b0);
    chk1("midrst_ready", ex_ready, 1'b1);

    run_op(64'h8000_0030, 3'b101, 1'b0, 64'd0, 1, 1, 64'hFFFF_0000_8001_7FFF, 1'b0, 0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
